// File: rtl/gshare_bpu_pkg.sv
// Shared constants and index/tag helpers for the gshare branch predictor.
package bpu_pkg;

    // Default geometry; modules take their own parameters, these are the reference sizes.
    localparam int XLEN_DEF      = 32;
    localparam int GHR_W_DEF     = 8;
    localparam int PHT_IDX_W_DEF = 8;
    localparam int BTB_IDX_W_DEF = 4;
    localparam int CTR_W_DEF     = 2;

    // Saturating counter constants (2-bit: 0..3, reset to weakly not-taken).
    localparam int CTR_MAX  = (1 << CTR_W_DEF) - 1;
    localparam int CTR_INIT = 1;

    // BTB entry field widths: tag is what remains above the index and byte offset.
    localparam int BTB_TAG_W_DEF = XLEN_DEF - BTB_IDX_W_DEF - 2;
    localparam int BTB_TGT_W_DEF = XLEN_DEF;

    function automatic int btb_tag_w(input int xlen, input int idx_w);
        return xlen - idx_w - 2;
    endfunction

    // gshare index: word-aligned PC bits XOR zero-extended history, masked to idx_w bits.
    function automatic logic [63:0] pht_index(input logic [63:0] pc,
                                              input logic [63:0] ghr,
                                              input int          idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return ((pc >> 2) ^ ghr) & mask;
    endfunction

    // BTB tag: everything above the BTB index bits; caller truncates to tag width.
    function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/gshare_bpu_pht.sv
// Pattern history table: array of saturating counters, one async read, one sync update.
module bpu_pht #(
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CTR_W-1:0] o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);
    localparam int               N      = 1 << IDX_W;
    localparam logic [CTR_W-1:0] C_MAX  = '1;
    localparam logic [CTR_W-1:0] C_INIT = CTR_W'(CTR_INIT);

    logic [CTR_W-1:0] r_ctr [N];
    logic [CTR_W-1:0] w_cur;

    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = r_ctr[i_upd_idx];

    // Reset every counter; otherwise step the addressed counter toward the outcome, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_ctr[i] <= C_INIT;
        end else if (i_upd_en) begin
            if (i_upd_taken && w_cur != C_MAX)
                r_ctr[i_upd_idx] <= w_cur + 1'b1;
            else if (!i_upd_taken && w_cur != '0)
                r_ctr[i_upd_idx] <= w_cur - 1'b1;
        end
    end

endmodule

// File: rtl/gshare_bpu.sv
// gshare predictor: tagged direct-mapped BTB, PHT, speculative GHR with checkpoint repair.
module gshare_bpu
    import bpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int GHR_W     = 8,
    parameter int PHT_IDX_W = 8,
    parameter int BTB_IDX_W = 4,
    parameter int CTR_W     = 2,
    parameter int CTR_INIT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_valid,
    input  logic                 f_stall,
    input  logic [XLEN-1:0]      f_pc,
    output logic                 pred_hit,
    output logic                 pred_is_jump,
    output logic                 pred_taken,
    output logic [XLEN-1:0]      pred_target,
    output logic [GHR_W-1:0]     pred_ghr,
    output logic [PHT_IDX_W-1:0] pred_pht_idx,
    input  logic                 e_valid,
    input  logic [XLEN-1:0]      e_pc,
    input  logic                 e_is_branch,
    input  logic                 e_is_jump,
    input  logic                 e_taken,
    input  logic [XLEN-1:0]      e_target,
    input  logic                 e_pred_taken,
    input  logic [XLEN-1:0]      e_pred_target,
    input  logic [GHR_W-1:0]     e_ghr,
    input  logic [PHT_IDX_W-1:0] e_pht_idx,
    output logic                 e_mispredict,
    output logic [XLEN-1:0]      e_redirect_pc
);
    localparam int TAG_W = btb_tag_w(XLEN, BTB_IDX_W);
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic [GHR_W-1:0]     r_ghr;
    logic [BTB_N-1:0]     r_btb_vld;
    logic [BTB_N-1:0]     r_btb_jmp;
    logic [TAG_W-1:0]     r_btb_tag [BTB_N];
    logic [XLEN-1:0]      r_btb_tgt [BTB_N];

    logic [BTB_IDX_W-1:0] w_fidx, w_eidx;
    logic [TAG_W-1:0]     w_ftag, w_etag;
    logic [CTR_W-1:0]     w_ctr;
    logic                 w_ctl, w_etaken, w_alias, w_fshift, w_btb_wr, w_btb_clr;

    // ---- fetch-side lookup ----
    assign w_fidx       = f_pc[BTB_IDX_W+1:2];
    assign w_ftag       = TAG_W'(btb_tag(64'(f_pc), BTB_IDX_W));
    assign pred_pht_idx = PHT_IDX_W'(pht_index(64'(f_pc), 64'(r_ghr), PHT_IDX_W));
    assign pred_hit     = r_btb_vld[w_fidx] && (r_btb_tag[w_fidx] == w_ftag);
    assign pred_is_jump = pred_hit && r_btb_jmp[w_fidx];
    assign pred_target  = r_btb_tgt[w_fidx];
    assign pred_taken   = pred_hit && (pred_is_jump || w_ctr[CTR_W-1]);
    assign pred_ghr     = r_ghr;

    // Only conditional branches that hit the BTB feed speculative history.
    assign w_fshift = f_valid && !f_stall && pred_hit && !pred_is_jump;

    // ---- execute-side resolution ----
    assign w_ctl    = e_is_branch | e_is_jump;
    assign w_etaken = e_taken | e_is_jump;
    // A non-control instruction that was predicted taken hit a stale/aliased BTB entry.
    assign w_alias  = !w_ctl && e_pred_taken;
    assign e_mispredict = e_valid && (
                              (w_ctl && (w_etaken != e_pred_taken)) ||
                              (w_etaken && (e_target != e_pred_target)) ||
                              w_alias);
    assign e_redirect_pc = w_etaken ? e_target : e_pc + XLEN'(4);

    assign w_eidx    = e_pc[BTB_IDX_W+1:2];
    assign w_etag    = TAG_W'(btb_tag(64'(e_pc), BTB_IDX_W));
    assign w_btb_wr  = e_valid && w_ctl && w_etaken;
    assign w_btb_clr = e_valid && w_alias;

    bpu_pht #(
        .IDX_W    (PHT_IDX_W),
        .CTR_W    (CTR_W),
        .CTR_INIT (CTR_INIT)
    ) u_pht (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (pred_pht_idx),
        .o_rd_ctr    (w_ctr),
        .i_upd_en    (e_valid && e_is_branch),
        .i_upd_idx   (e_pht_idx),
        .i_upd_taken (w_etaken)
    );

    // History: repair from the carried checkpoint beats the same-cycle fetch shift.
    always_ff @(posedge clk) begin
        if (rst)
            r_ghr <= '0;
        else if (e_mispredict)
            r_ghr <= e_is_branch ? GHR_W'({e_ghr, w_etaken}) : e_ghr;
        else if (w_fshift)
            r_ghr <= GHR_W'({r_ghr, pred_taken});
    end

    // BTB valid bits: allocate on taken control flow, drop on alias.
    always_ff @(posedge clk) begin
        if (rst)
            r_btb_vld <= '0;
        else if (w_btb_wr)
            r_btb_vld[w_eidx] <= 1'b1;
        else if (w_btb_clr)
            r_btb_vld[w_eidx] <= 1'b0;
    end

    // BTB payload needs no reset; it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && w_btb_wr) begin
            r_btb_tag[w_eidx] <= w_etag;
            r_btb_tgt[w_eidx] <= e_target;
            r_btb_jmp[w_eidx] <= e_is_jump;
        end
    end

endmodule

// File: tb/tb_gshare_bpu.sv
// Self-checking bench for gshare_bpu: directed table, counter corner cases, random vs model.
module tb_gshare_bpu;

    logic        clk = 1'b0;
    logic        rst, f_valid, f_stall;
    logic [31:0] f_pc;
    logic        pred_hit, pred_is_jump, pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr, pred_pht_idx;
    logic        e_valid, e_is_branch, e_is_jump, e_taken, e_pred_taken;
    logic [31:0] e_pc, e_target, e_pred_target;
    logic [7:0]  e_ghr, e_pht_idx;
    logic        e_mispredict;
    logic [31:0] e_redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gshare_bpu dut (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_stall(f_stall), .f_pc(f_pc),
        .pred_hit(pred_hit), .pred_is_jump(pred_is_jump), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ghr(pred_ghr), .pred_pht_idx(pred_pht_idx),
        .e_valid(e_valid), .e_pc(e_pc), .e_is_branch(e_is_branch), .e_is_jump(e_is_jump),
        .e_taken(e_taken), .e_target(e_target), .e_pred_taken(e_pred_taken),
        .e_pred_target(e_pred_target), .e_ghr(e_ghr), .e_pht_idx(e_pht_idx),
        .e_mispredict(e_mispredict), .e_redirect_pc(e_redirect_pc)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, fv, fs;
        logic [31:0] fpc;
        logic        ev, eb, ej, et, ept;
        logic [31:0] epc, etgt, eptgt;
        logic [7:0]  eghr, epidx;
        logic        chk;
        logic        xhit, xjmp, xtkn;
        logic [31:0] xtgt;
        logic [7:0]  xghr, xpidx;
        logic        xmis;
        logic [31:0] xred;
    } vec_t;

    function automatic vec_t V(
        input logic r, input logic fv, input logic fs, input logic [31:0] fpc,
        input logic ev, input logic eb, input logic ej, input logic et,
        input logic [31:0] epc, input logic [31:0] etgt, input logic ept,
        input logic [31:0] eptgt, input logic [7:0] eghr, input logic [7:0] epidx,
        input logic c, input logic xh, input logic xj, input logic xt,
        input logic [31:0] xtg, input logic [7:0] xg, input logic [7:0] xp,
        input logic xm, input logic [31:0] xr);
        vec_t v;
        v.rst = r; v.fv = fv; v.fs = fs; v.fpc = fpc;
        v.ev = ev; v.eb = eb; v.ej = ej; v.et = et; v.epc = epc; v.etgt = etgt;
        v.ept = ept; v.eptgt = eptgt; v.eghr = eghr; v.epidx = epidx;
        v.chk = c; v.xhit = xh; v.xjmp = xj; v.xtkn = xt; v.xtgt = xtg;
        v.xghr = xg; v.xpidx = xp; v.xmis = xm; v.xred = xr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; f_valid = v.fv; f_stall = v.fs; f_pc = v.fpc;
        e_valid = v.ev; e_is_branch = v.eb; e_is_jump = v.ej; e_taken = v.et;
        e_pc = v.epc; e_target = v.etgt; e_pred_taken = v.ept;
        e_pred_target = v.eptgt; e_ghr = v.eghr; e_pht_idx = v.epidx;
    endtask

    // ---- behavioural reference model ----
    bit          m_v   [16];
    bit          m_j   [16];
    int unsigned m_tag [16];
    int unsigned m_tgt [16];
    int          m_ctr [256];
    int unsigned m_ghr;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_v[i] = 0;
        for (int i = 0; i < 256; i++) m_ctr[i] = 1;
        m_ghr = 0;
    endtask

    function automatic logic [31:0] pool_pc();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    // Counter training through the execute port, observing the addressed counter.
    task automatic train(input logic tk, input int exp_ctr, input string nm);
        @(negedge clk);
        rst = 0; f_valid = 0; f_stall = 0; f_pc = 0;
        e_valid = 1; e_is_branch = 1; e_is_jump = 0; e_taken = tk;
        e_pc = 32'h100; e_target = 32'h80; e_pred_taken = tk; e_pred_target = 32'h80;
        e_ghr = 0; e_pht_idx = 8'h40;
        @(posedge clk);
        #1;
        chk(nm, 64'(dut.u_pht.r_ctr[8'h40]), 64'(exp_ctr));
    endtask

    vec_t tbl [15];

    initial begin
        rst = 1; f_valid = 0; f_stall = 0; f_pc = 0;
        e_valid = 0; e_is_branch = 0; e_is_jump = 0; e_taken = 0; e_pred_taken = 0;
        e_pc = 0; e_target = 0; e_pred_target = 0; e_ghr = 0; e_pht_idx = 0;

        //          r fv fs fpc        ev eb ej et epc         etgt    ept eptgt  eghr   epidx c  h j t tgt       ghr    pidx  mis red
        tbl[0]  = V(1,0,0,32'h0,       0,0,0,0,32'h0,      32'h0,  0,32'h0, 8'h0,  8'h0,  0, 0,0,0,32'h0,   8'h0,  8'h0,  0,32'h0);
        tbl[1]  = V(0,1,0,32'h100,     1,1,0,1,32'h100,    32'h80, 0,32'h0, 8'h0,  8'h40, 1, 0,0,0,32'h0,   8'h0,  8'h40, 1,32'h80);
        tbl[2]  = V(0,1,0,32'h100,     0,0,0,0,32'h0,      32'h0,  0,32'h0, 8'h0,  8'h0,  1, 1,0,0,32'h80,  8'h01, 8'h41, 0,32'h4);
        tbl[3]  = V(0,0,0,32'h0,       1,0,1,1,32'h200,    32'h400,0,32'h0, 8'h02, 8'h0,  1, 0,0,0,32'h0,   8'h02, 8'h02, 1,32'h400);
        tbl[4]  = V(0,1,0,32'h200,     0,0,0,0,32'h0,      32'h0,  0,32'h0, 8'h0,  8'h0,  1, 1,1,1,32'h400, 8'h02, 8'h82, 0,32'h4);
        tbl[5]  = V(0,1,0,32'h100,     0,0,0,0,32'h0,      32'h0,  0,32'h0, 8'h0,  8'h0,  1, 0,0,0,32'h0,   8'h02, 8'h42, 0,32'h4);
        tbl[6]  = V(0,0,0,32'h200,     1,0,0,0,32'h200,    32'h0,  1,32'h0, 8'h33, 8'h0,  1, 1,1,1,32'h400, 8'h02, 8'h82, 1,32'h204);
        tbl[7]  = V(0,0,0,32'h200,     0,0,0,0,32'h0,      32'h0,  0,32'h0, 8'h0,  8'h0,  1, 0,0,0,32'h0,   8'h33, 8'hB3, 0,32'h4);
        tbl[8]  = V(0,0,0,32'h500,     1,1,0,1,32'h100,    32'h80, 1,32'h80,8'h0,  8'h40, 1, 0,0,0,32'h0,   8'h33, 8'h73, 0,32'h80);
        tbl[9]  = V(0,0,0,32'h500,     0,0,0,0,32'h0,      32'h0,  0,32'h0, 8'h0,  8'h0,  1, 0,0,0,32'h0,   8'h33, 8'h73, 0,32'h4);
        tbl[10] = V(0,1,0,32'h100,     1,1,0,0,32'h300,    32'h0,  1,32'h0, 8'hA5, 8'h10, 1, 1,0,0,32'h80,  8'h33, 8'h73, 1,32'h304);
        tbl[11] = V(0,0,0,32'h100,     0,0,0,0,32'h0,      32'h0,  0,32'h0, 8'h0,  8'h0,  1, 1,0,0,32'h80,  8'h4A, 8'h0A, 0,32'h4);
        tbl[12] = V(0,0,0,32'h100,     0,0,0,0,32'hFFFFFFFC,32'h0, 1,32'h0, 8'h77, 8'h0,  1, 1,0,0,32'h80,  8'h4A, 8'h0A, 0,32'h0);
        tbl[13] = V(1,1,0,32'h100,     1,1,0,1,32'h100,    32'h80, 0,32'h0, 8'h11, 8'h40, 1, 1,0,0,32'h80,  8'h4A, 8'h0A, 1,32'h80);
        tbl[14] = V(0,0,0,32'h100,     0,0,0,0,32'h0,      32'h0,  0,32'h0, 8'h0,  8'h0,  1, 0,0,0,32'h0,   8'h0,  8'h40, 0,32'h4);

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(tbl[k]);
            #1;
            if (tbl[k].chk) begin
                chk($sformatf("t%0d_hit", k),   64'(pred_hit),      64'(tbl[k].xhit));
                chk($sformatf("t%0d_jmp", k),   64'(pred_is_jump),  64'(tbl[k].xjmp));
                chk($sformatf("t%0d_tkn", k),   64'(pred_taken),    64'(tbl[k].xtkn));
                if (tbl[k].xhit)
                    chk($sformatf("t%0d_tgt", k), 64'(pred_target), 64'(tbl[k].xtgt));
                chk($sformatf("t%0d_ghr", k),   64'(pred_ghr),      64'(tbl[k].xghr));
                chk($sformatf("t%0d_pidx", k),  64'(pred_pht_idx),  64'(tbl[k].xpidx));
                chk($sformatf("t%0d_mis", k),   64'(e_mispredict),  64'(tbl[k].xmis));
                chk($sformatf("t%0d_red", k),   64'(e_redirect_pc), 64'(tbl[k].xred));
            end
            @(posedge clk);
        end

        // Table ended with a reset cycle: every counter must be back at its initial value.
        begin
            int not_init = 0;
            #1;
            for (int i = 0; i < 256; i++)
                if (dut.u_pht.r_ctr[i] != 2'd1) not_init++;
            chk("ctr_reset_all", 64'(not_init), 64'd0);
        end

        // Saturation up, then down.
        train(1, 2, "sat_t1"); train(1, 3, "sat_t2"); train(1, 3, "sat_t3"); train(1, 3, "sat_t4");
        train(0, 2, "sat_n1"); train(0, 1, "sat_n2"); train(0, 0, "sat_n3"); train(0, 0, "sat_n4");

        // ---- randomized run against the model ----
        @(negedge clk);
        rst = 1; e_valid = 0; f_valid = 0;
        @(posedge clk);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            int unsigned bi, pi, kind;
            bit hit, jmp, tk, ctl, etk, mis, alias_c;
            logic [31:0] red;
            @(negedge clk);
            rst           = ($urandom_range(0, 99) == 0);
            f_valid       = $urandom_range(0, 1) == 1;
            f_stall       = ($urandom_range(0, 3) == 0);
            f_pc          = pool_pc();
            e_valid       = ($urandom_range(0, 3) != 0);
            kind          = $urandom_range(0, 2);
            e_is_branch   = (kind == 1);
            e_is_jump     = (kind == 2);
            e_taken       = $urandom_range(0, 1) == 1;
            e_pc          = ($urandom_range(0, 31) == 0) ? 32'hFFFFFFFC : pool_pc();
            e_target      = 32'($urandom_range(0, 7)) << 4;
            e_pred_taken  = $urandom_range(0, 1) == 1;
            e_pred_target = $urandom_range(0, 1) ? e_target : 32'($urandom_range(0, 7)) << 4;
            e_ghr         = 8'($urandom);
            e_pht_idx     = 8'($urandom);
            #1;
            bi  = (f_pc >> 2) % 16;
            hit = m_v[bi] && (m_tag[bi] == (f_pc >> 6));
            jmp = hit && m_j[bi];
            pi  = ((f_pc >> 2) % 256) ^ m_ghr;
            tk  = hit && (jmp || m_ctr[pi] >= 2);
            ctl = e_is_branch || e_is_jump;
            etk = e_taken || e_is_jump;
            alias_c = !ctl && e_pred_taken;
            mis = e_valid && ((ctl && (etk != e_pred_taken)) ||
                              (etk && (e_target != e_pred_target)) || alias_c);
            red = etk ? e_target : e_pc + 32'd4;

            chk("r_hit",  64'(pred_hit),      64'(hit));
            chk("r_jmp",  64'(pred_is_jump),  64'(jmp));
            chk("r_tkn",  64'(pred_taken),    64'(tk));
            if (hit) chk("r_tgt", 64'(pred_target), 64'(m_tgt[bi]));
            chk("r_ghr",  64'(pred_ghr),      64'(m_ghr));
            chk("r_pidx", 64'(pred_pht_idx),  64'(pi));
            chk("r_mis",  64'(e_mispredict),  64'(mis));
            chk("r_red",  64'(e_redirect_pc), 64'(red));

            if (rst) begin
                model_reset();
            end else begin
                if (mis)
                    m_ghr = e_is_branch ? ((32'(e_ghr) * 2 + 32'(etk)) % 256) : 32'(e_ghr);
                else if (f_valid && !f_stall && hit && !jmp)
                    m_ghr = (m_ghr * 2 + 32'(tk)) % 256;
                if (e_valid && e_is_branch) begin
                    if (etk && m_ctr[e_pht_idx] < 3) m_ctr[e_pht_idx]++;
                    else if (!etk && m_ctr[e_pht_idx] > 0) m_ctr[e_pht_idx]--;
                end
                if (e_valid && ctl && etk) begin
                    m_v[(e_pc >> 2) % 16]   = 1;
                    m_tag[(e_pc >> 2) % 16] = e_pc >> 6;
                    m_tgt[(e_pc >> 2) % 16] = e_target;
                    m_j[(e_pc >> 2) % 16]   = e_is_jump;
                end else if (e_valid && alias_c) begin
                    m_v[(e_pc >> 2) % 16] = 0;
                end
            end
            @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gshare_bpu.md
Name: gshare_bpu

Overview:
- Parametrised successor to the fixed 8-bit gshare/BTB prediction path of the RV32I 5-stage pipeline.
- Combines in one unit:
  - a tagged, direct-mapped BTB;
  - a gshare PHT of CTR_W-bit saturating counters;
  - a speculatively updated global history register (GHR) with checkpoint repair on mispredict.
- Fetch-side lookup is combinational off F_PC. The execute stage returns resolution and gets back a mispredict flag and a redirect PC.
- Adds behaviour the previous unit lacked: tag check, speculative history, and alias invalidation.

Parameters:
- XLEN, 32, address/data width
- GHR_W, 8, global history length; must be <= PHT_IDX_W
- PHT_IDX_W, 8, log2 PHT entries
- BTB_IDX_W, 4, log2 BTB entries
- CTR_W, 2, PHT counter width
- CTR_INIT, 1, counter reset value (weakly not-taken for CTR_W=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- f_valid  in  1  fetch slot valid
- f_stall  in  1  fetch held; no speculative state change
- f_pc  in  XLEN  fetch PC
- pred_hit  out  1  BTB tag hit and valid
- pred_is_jump  out  1  hit entry is unconditional
- pred_taken  out  1  final prediction
- pred_target  out  XLEN  BTB target (valid when pred_hit)
- pred_ghr  out  GHR_W  GHR value before this fetch's update (checkpoint)
- pred_pht_idx  out  PHT_IDX_W  PHT index used
- e_valid  in  1  execute slot valid (not flushed)
- e_pc  in  XLEN  resolving instruction PC
- e_is_branch / e_is_jump  in  1 each  decoded type
- e_taken  in  1  actual outcome (jump forces 1)
- e_target  in  XLEN  actual target
- e_pred_taken  in  1  prediction carried down the pipe
- e_pred_target  in  XLEN  predicted target carried down the pipe
- e_ghr  in  GHR_W  checkpoint carried down the pipe
- e_pht_idx  in  PHT_IDX_W  index carried down the pipe
- e_mispredict  out  1  flush F/D/E and redirect
- e_redirect_pc  out  XLEN  correct next PC

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at clk edge):
  - GHR=0; all BTB valid=0; all PHT counters=CTR_INIT.
  - Outputs are combinational from state, so after reset: pred_hit=0, pred_taken=0, pred_ghr=0. e_mispredict follows inputs.
- Lookup (combinational, zero latency):
  - BTB index = f_pc[BTB_IDX_W+1:2]; tag = f_pc[XLEN-1:BTB_IDX_W+2].
  - PHT index = f_pc[PHT_IDX_W+1:2] XOR zero-extended GHR.
  - pred_taken = pred_hit & (pred_is_jump | counter MSB).
- Speculative GHR update at clock edge:
  - When f_valid & !f_stall & pred_hit & !pred_is_jump: GHR <= {GHR[GHR_W-2:0], pred_taken}.
  - Jumps and BTB misses do not shift.
- Mispredict (combinational); M is true for any of:
  - (e_is_branch|e_is_jump) & (e_taken != e_pred_taken);
  - e_taken & (e_target != e_pred_target);
  - !e_is_branch & !e_is_jump & e_pred_taken (alias).
  - e_mispredict = e_valid & M.
  - e_redirect_pc = e_taken ? e_target : e_pc+4, wrapping mod 2^XLEN.
- GHR repair:
  - On e_mispredict with e_is_branch: GHR <= {e_ghr[GHR_W-2:0], e_taken}.
  - On any other e_mispredict: GHR <= e_ghr.
  - Repair has priority over the same-cycle fetch shift.
- PHT update:
  - Only when e_valid & e_is_branch.
  - Counter at e_pht_idx increments on taken and decrements otherwise, saturating at 0 and 2^CTR_W-1.
- BTB update:
  - e_valid & (e_is_branch|e_is_jump) & e_taken: write valid=1, tag, target=e_target, is_jump=e_is_jump. Overwrites any conflicting entry.
  - Alias case: clear valid at the e_pc index.
  - Not-taken branches never allocate.
- Read/write ordering:
  - Same-cycle lookup sees pre-update BTB/PHT/GHR (no bypass).
  - Writes are visible from the next cycle.
- rst asserted mid-operation overrides all updates that cycle.
- Inputs with e_valid=0 cause no state change.

Decomposition:
- Package bpu_pkg holds:
  - counter constants: CTR_MAX, CTR_INIT;
  - BTB entry field widths;
  - functions pht_index(pc, ghr) and btb_tag(pc).
- Sub-module bpu_pht:
  - parametrised saturating-counter array;
  - one combinational read port and one synchronous update port.
- BTB and GHR logic stay in gshare_bpu.

Test Plan:
- Reset, then f_pc=0x100 -> pred_hit=0, pred_taken=0, pred_ghr=0; every counter reads 1.
- Resolve branch e_pc=0x100 taken to 0x80 with e_pred_taken=0, e_ghr=0 -> e_mispredict=1, e_redirect_pc=0x80.
  - Next cycle: GHR=0x01, counter[idx]=2.
  - Fetch f_pc=0x100 -> pred_hit=1, pred_target=0x80.
- Train the same branch taken 3× -> counter saturates at 3. A fourth taken resolution leaves it 3. Then not-taken ×4 -> counter reaches 0 and stays 0.
- Jump e_pc=0x200 to 0x400 resolved, then fetch 0x200 -> pred_is_jump=1, pred_taken=1, GHR unchanged by fetch.
- Alias: e_pc=0x104 non-branch with e_pred_taken=1 -> e_mispredict=1, e_redirect_pc=0x108, BTB entry invalidated, GHR <= e_ghr.
- Same cycle: fetch shifts GHR while execute mispredicts with e_ghr=0xA5, e_taken=0 -> GHR=0x4A (repair wins). Tag mismatch at the same index (0x100 vs 0x500, BTB_IDX_W=4) -> pred_hit=0.
